// File: rtl/timer_pkg.sv
// Shared constants and address decode helper for the memory-mapped reload timer.
package timer_pkg;

  // Word address of TH; TL and TCON follow at +4 and +8.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Byte offsets of the three registers from the base address.
  localparam logic [31:0] TH_OFF   = 32'd0;
  localparam logic [31:0] TL_OFF   = 32'd4;
  localparam logic [31:0] TCON_OFF = 32'd8;

  // TCON bit positions: enable, interrupt enable, pending status.
  localparam int TCON_EN   = 0;
  localparam int TCON_IE   = 1;
  localparam int TCON_PEND = 2;

  // Which timer register (if any) the bus address selects.
  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_TH   = 2'd1,
    REG_TL   = 2'd2,
    REG_TCON = 2'd3
  } reg_sel_e;

  // Word-granular decode: the two byte-select bits of the address are masked off.
  function automatic reg_sel_e decode_reg(input logic [31:0] addr, input logic [31:0] base);
    logic [31:0] word_mask;
    word_mask  = 32'hFFFF_FFFC;
    decode_reg = REG_NONE;
    if ((addr & word_mask) == ((base + TH_OFF) & word_mask)) begin
      decode_reg = REG_TH;
    end else if ((addr & word_mask) == ((base + TL_OFF) & word_mask)) begin
      decode_reg = REG_TL;
    end else if ((addr & word_mask) == ((base + TCON_OFF) & word_mask)) begin
      decode_reg = REG_TCON;
    end
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock down to the TL increment rate.
// tick is combinational from the current count and enable, so a tick is
// visible in the same cycle the timer register logic decides what to do.
module timer_prescaler #(
  parameter int PRESCALE = 1,
  parameter int PS_W     = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] count;

  // With PRESCALE=1, LAST is 0 and the count never leaves 0, so tick simply
  // follows en; the same expression covers every legal divide ratio.
  assign tick = en && (count == LAST);

  // Count 0..PRESCALE-1 while enabled; held at 0 when disabled or on a TL write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!en || clr || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_irq_unit.sv
// Memory-mapped 32-bit reload timer and interrupt source for the core.
//
// Bus semantics: there is no handshake and no wait state. A store takes
// effect on the clock edge where MemWrite=1 and addr selects a register; a
// load returns data combinationally in the same cycle where MemRead=1 and
// addr selects a register, and has no side effects. When both strobes are
// high on the same register, rdata shows the value before the store lands.
module timer_irq_unit
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          PRESCALE  = 1,
  parameter int          PS_W      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        IRQ
);

  logic [31:0] th;
  logic [31:0] tl;
  logic        tcon_en;
  logic        tcon_ie;
  logic        tcon_pend;

  reg_sel_e hit;
  logic     wr_th;
  logic     wr_tl;
  logic     wr_tcon;
  logic     tick;
  logic     overflow;

  assign hit     = decode_reg(addr, BASE_ADDR);
  assign sel     = (hit != REG_NONE);
  assign wr_th   = MemWrite && (hit == REG_TH);
  assign wr_tl   = MemWrite && (hit == REG_TL);
  assign wr_tcon = MemWrite && (hit == REG_TCON);

  // A TL store restarts the prescale window so the new value gets a full period.
  timer_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (tcon_en),
    .clr   (wr_tl),
    .tick  (tick)
  );

  // A TL store on the overflow cycle wins, so that overflow never happened.
  assign overflow = tick && (tl == 32'hFFFF_FFFF) && !wr_tl;

  // Reload value register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th <= '0;
    end else if (wr_th) begin
      th <= wdata;
    end
  end

  // Counter: store wins over tick; on overflow it reloads the pre-store TH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl <= '0;
    end else if (wr_tl) begin
      tl <= wdata;
    end else if (tick) begin
      tl <= (tl == 32'hFFFF_FFFF) ? th : tl + 32'd1;
    end
  end

  // Control bits; pending is write-0-to-clear and a same-edge set beats the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon_en   <= 1'b0;
      tcon_ie   <= 1'b0;
      tcon_pend <= 1'b0;
    end else begin
      if (wr_tcon) begin
        tcon_en <= wdata[TCON_EN];
        tcon_ie <= wdata[TCON_IE];
      end
      if (overflow && tcon_ie) begin
        tcon_pend <= 1'b1;
      end else if (wr_tcon && !wdata[TCON_PEND]) begin
        tcon_pend <= 1'b0;
      end
    end
  end

  // Read mux; zero whenever the load strobe is low or no register is selected.
  always_comb begin
    rdata = '0;
    if (MemRead) begin
      case (hit)
        REG_TH:   rdata = th;
        REG_TL:   rdata = tl;
        REG_TCON: rdata = {29'd0, tcon_pend, tcon_ie, tcon_en};
        default:  rdata = '0;
      endcase
    end
  end

  // IRQ is the registered pending bit itself: no path from tick to IRQ.
  assign IRQ = tcon_pend;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Bench for timer_irq_unit: directed scenario tasks plus a randomized run
// checked against a cycle-level reference model of the register behaviour.
module tb_timer_irq_unit;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_BAD  = 32'h4000_000C;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] rdata1, rdata4;
  logic        sel1, sel4, irq1, irq4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  timer_irq_unit #(.PRESCALE(1), .PS_W(16)) dut1 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .rdata(rdata1), .sel(sel1), .IRQ(irq1)
  );

  timer_irq_unit #(.PRESCALE(4), .PS_W(16)) dut4 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .rdata(rdata4), .sel(sel4), .IRQ(irq4)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    addr = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v1, output logic [31:0] v4);
    addr = a;
    MemRead = 1'b1;
    #1;
    v1 = rdata1;
    v4 = rdata4;
    MemRead = 1'b0;
    addr = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] v1, v4;
    logic [31:0] regs [3];
    regs[0] = A_TH; regs[1] = A_TL; regs[2] = A_TCON;
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      rd(regs[i], v1, v4);
      n_tests++;
      if (v1 !== 32'd0 || v4 !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h/%h expected 0", i, v1, v4);
      end
    end
    n_tests++;
    if (irq1 !== 1'b0 || irq4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_irq: got %b/%b expected 0", irq1, irq4);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_overflow_irq();
    logic [31:0] v1, v4;
    apply_reset();
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL ovf_tl0: got %h expected fffffffe", v1); end
    step();
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'hFFFF_FFFF || irq1 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_tl1: got %h irq %b expected ffffffff irq 0", v1, irq1);
    end
    step();
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL ovf_reload: got %h expected fffffff0", v1); end
    rd(A_TCON, v1, v4);
    n_tests++;
    if (v1 !== 32'd7 || irq1 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pend: tcon %h irq %b expected 7 irq 1", v1, irq1);
    end
    // Writing 1 to the pending bit leaves it set.
    wr(A_TCON, 32'd7);
    rd(A_TCON, v1, v4);
    n_tests++;
    if (v1 !== 32'd7 || irq1 !== 1'b1) begin
      n_fail++; $display("FAIL keep_pend: tcon %h irq %b expected 7 irq 1", v1, irq1);
    end
    // Writing 0 to it clears it.
    wr(A_TCON, 32'd3);
    rd(A_TCON, v1, v4);
    n_tests++;
    if (v1 !== 32'd3 || irq1 !== 1'b0) begin
      n_fail++; $display("FAIL clear_pend: tcon %h irq %b expected 3 irq 0", v1, irq1);
    end
  endtask

  task automatic test_no_ie();
    logic [31:0] v1, v4;
    int bad;
    apply_reset();
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd1);
    step();
    step();
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL noie_reload: got %h expected fffffff0", v1); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (irq1 !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL noie_irq: irq high %0d cycles expected 0", bad); end
    rd(A_TCON, v1, v4);
    n_tests++;
    if (v1 !== 32'd1) begin n_fail++; $display("FAIL noie_tcon: got %h expected 1", v1); end
  endtask

  task automatic test_clear_race();
    logic [31:0] v1, v4;
    apply_reset();
    wr(A_TH, 32'hFFFF_FFF0);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    step();
    wr(A_TCON, 32'd3);  // lands on the overflow edge
    rd(A_TCON, v1, v4);
    n_tests++;
    if (v1 !== 32'd7 || irq1 !== 1'b1) begin
      n_fail++; $display("FAIL clear_race: tcon %h irq %b expected 7 irq 1", v1, irq1);
    end
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL clear_race_tl: got %h expected fffffff0", v1); end
  endtask

  task automatic test_write_races();
    logic [31:0] v1, v4;
    // TH store on the overflow edge: old TH reloads, new TH on the next overflow.
    apply_reset();
    wr(A_TH, 32'd10);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd1);
    wr(A_TH, 32'd20);
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'd10) begin n_fail++; $display("FAIL th_race_old: got %h expected a", v1); end
    wr(A_TL, 32'hFFFF_FFFF);
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tl_write_over_tick: got %h expected ffffffff", v1); end
    step();
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'd20) begin n_fail++; $display("FAIL th_race_new: got %h expected 14", v1); end
    // TL store on an overflow edge: no increment and no pending bit.
    apply_reset();
    wr(A_TH, 32'd5);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    wr(A_TL, 32'd100);
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'd100) begin n_fail++; $display("FAIL tl_wins: got %h expected 64", v1); end
    rd(A_TCON, v1, v4);
    n_tests++;
    if (v1 !== 32'd3 || irq1 !== 1'b0) begin
      n_fail++; $display("FAIL tl_wins_pend: tcon %h irq %b expected 3 irq 0", v1, irq1);
    end
    // Disabling on a tick cycle: that tick still counts, then counting stops.
    apply_reset();
    wr(A_TL, 32'd50);
    wr(A_TCON, 32'd1);
    wr(A_TCON, 32'd0);
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'd51) begin n_fail++; $display("FAIL disable_tick: got %h expected 33", v1); end
    step();
    step();
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'd51) begin n_fail++; $display("FAIL disable_hold: got %h expected 33", v1); end
    // Load and store on the same register: load sees the old value.
    wr(A_TH + 32'd3, 32'h11);
    addr = A_TH + 32'd1;
    wdata = 32'h22;
    MemWrite = 1'b1;
    MemRead = 1'b1;
    #1;
    n_tests++;
    if (rdata1 !== 32'h11 || sel1 !== 1'b1) begin
      n_fail++; $display("FAIL rw_same: got %h sel %b expected 11 sel 1", rdata1, sel1);
    end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    MemRead = 1'b0;
    // Stores outside the register window change nothing.
    wr(A_BAD, 32'hFFFF_FFFF);
    rd(A_TH + 32'd2, v1, v4);
    n_tests++;
    if (v1 !== 32'h22) begin n_fail++; $display("FAIL rw_new_th: got %h expected 22", v1); end
    rd(A_TCON, v1, v4);
    n_tests++;
    if (v1 !== 32'd0) begin n_fail++; $display("FAIL bad_write_tcon: got %h expected 0", v1); end
  endtask

  task automatic test_prescale();
    logic [31:0] v1, v4;
    logic [31:0] exp;
    apply_reset();
    wr(A_TL, 32'd0);
    wr(A_TCON, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      rd(A_TL, v1, v4);
      exp = (i == 4) ? 32'd1 : 32'd0;
      n_tests++;
      if (v4 !== exp) begin n_fail++; $display("FAIL ps_cycle%0d: got %h expected %h", i, v4, exp); end
    end
    for (int i = 0; i < 16; i++) step();
    rd(A_TL, v1, v4);
    n_tests++;
    if (v4 !== 32'd5) begin n_fail++; $display("FAIL ps_20: got %h expected 5", v4); end
    step();
    step();
    wr(A_TL, 32'd9);
    for (int k = 1; k <= 4; k++) begin
      step();
      rd(A_TL, v1, v4);
      exp = (k == 4) ? 32'd10 : 32'd9;
      n_tests++;
      if (v4 !== exp) begin n_fail++; $display("FAIL ps_restart%0d: got %h expected %h", k, v4, exp); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v1, v4;
    apply_reset();
    wr(A_TH, 32'd122);
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    step();
    wr(A_TCON, 32'd6);  // stop counting, keep IE and pending
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'd123 || irq1 !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: tl %h irq %b expected 7b irq 1", v1, irq1);
    end
    reset = 1'b1;
    #1;
    rd(A_TH, v1, v4);
    n_tests++;
    if (v1 !== 32'd0) begin n_fail++; $display("FAIL mid_reset_th: got %h expected 0", v1); end
    rd(A_TL, v1, v4);
    n_tests++;
    if (v1 !== 32'd0) begin n_fail++; $display("FAIL mid_reset_tl: got %h expected 0", v1); end
    rd(A_TCON, v1, v4);
    n_tests++;
    if (v1 !== 32'd0 || irq1 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_tcon: tcon %h irq %b expected 0 irq 0", v1, irq1);
    end
    addr = A_BAD;
    MemRead = 1'b1;
    #1;
    n_tests++;
    if (sel1 !== 1'b0 || rdata1 !== 32'd0) begin
      n_fail++; $display("FAIL bad_addr_read: sel %b rdata %h expected 0 0", sel1, rdata1);
    end
    MemRead = 1'b0;
    addr = '0;
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  // Randomized run against a register-level reference model (PRESCALE=1 instance).
  task automatic test_random();
    logic [31:0] m_th, m_tl, n_tl, d, a, v1, v4, exp_tcon;
    logic        m_en, m_ie, m_pend, ovf;
    int          op;
    apply_reset();
    m_th = 0; m_tl = 0; m_en = 0; m_ie = 0; m_pend = 0;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 6);
      d = $urandom();
      case (op)
        1: a = A_TH;
        2: begin
          a = A_TL;
          if ($urandom_range(0, 3) != 0) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
        end
        3: begin a = A_TCON; d = 32'($urandom_range(0, 7)) | ($urandom() & 32'hFFFF_FFF8); end
        4: a = A_BAD;
        default: a = '0;
      endcase
      a = a | 32'($urandom_range(0, 3));
      // Reference: one tick per enabled cycle; stores to TL pre-empt the tick.
      ovf = m_en && (m_tl == 32'hFFFF_FFFF) && (op != 2);
      if (op == 2) n_tl = d;
      else if (m_en) n_tl = (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 1;
      else n_tl = m_tl;
      if (ovf && m_ie) m_pend = 1'b1;
      else if (op == 3 && d[2] == 1'b0) m_pend = 1'b0;
      if (op == 1) m_th = d;
      if (op == 3) begin m_en = d[0]; m_ie = d[1]; end
      m_tl = n_tl;
      if (op >= 1 && op <= 4) wr(a, d);
      else step();
      exp_tcon = {29'd0, m_pend, m_ie, m_en};
      rd(A_TH, v1, v4);
      n_tests++;
      if (v1 !== m_th) begin n_fail++; $display("FAIL rand_th it%0d: got %h expected %h", it, v1, m_th); end
      rd(A_TL, v1, v4);
      n_tests++;
      if (v1 !== m_tl) begin n_fail++; $display("FAIL rand_tl it%0d: got %h expected %h", it, v1, m_tl); end
      rd(A_TCON, v1, v4);
      n_tests++;
      if (v1 !== exp_tcon || irq1 !== m_pend) begin
        n_fail++; $display("FAIL rand_tcon it%0d: got %h irq %b expected %h irq %b", it, v1, irq1, exp_tcon, m_pend);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_overflow_irq();
    test_no_ie();
    test_clear_race();
    test_write_races();
    test_prescale();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
- Memory-mapped 32-bit reload timer; the interrupt source for the single-cycle core.
- Drives IRQ into the control decoder. The decoder masks IRQ with ker and selects PCSrc=4, which vectors the core to the interrupt handler.
- Sits on the data-memory bus beside RAM; responds to the three peripheral word addresses only.

Parameters:
- BASE_ADDR, 32'h40000000, word address of TH; TL is at BASE+4, TCON at BASE+8.
- PRESCALE, 1, core cycles per TL increment (legal range 1..65535).
- PS_W, 16, width of the prescale counter.

Ports:
- clk  in  1  core clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address from the ALU result.
- wdata  in  32  store data (rt).
- MemWrite  in  1  store strobe, qualified by address match.
- MemRead  in  1  load strobe, qualified by address match.
- rdata  out  32  combinational read data; 0 when not selected.
- sel  out  1  high when addr hits any timer register; used by the bus read-mux.
- IRQ  out  1  level interrupt request, equal to TCON[2].

Behaviour:
- Reset (async, high): TH=0, TL=0, TCON=3'b000, prescale count=0, IRQ=0.
- TCON[0] is enable, TCON[1] is interrupt enable, TCON[2] is pending status. Bits 31:3 read as 0 and ignore writes.
- Tick:
  - With PRESCALE=1, tick is high on every cycle that TCON[0]=1.
  - Otherwise the prescale counter counts 0..PRESCALE-1 while TCON[0]=1, and tick is high on the cycle the counter equals PRESCALE-1; the counter then wraps to 0.
  - While TCON[0]=0 the counter is held at 0.
- Count: on tick, if TL==32'hFFFFFFFF then TL<=TH (overflow), else TL<=TL+1. All arithmetic is unsigned, 32-bit, wrap-free.
- Overflow: if TCON[1]=1, TCON[2]<=1 on the same edge that reloads TL. IRQ follows TCON[2] from the next cycle; there is no combinational path from tick to IRQ.
- Writes are single-cycle and take effect at the clock edge when MemWrite=1 and addr matches:
  - TH write: TH<=wdata.
  - TL write: TL<=wdata; the prescale counter is reset to 0.
  - TCON write: TCON[1:0]<=wdata[1:0]. TCON[2] is write-0-to-clear: it is cleared only when wdata[2]=0. wdata[2]=1 leaves it unchanged.
- Reads: when MemRead=1 and addr matches, rdata is the current register value, combinationally, in the same cycle. Otherwise rdata=0. A read has no side effects.
- Simultaneous events:
  - TL write coinciding with a tick: the write wins and no increment occurs. If that tick was an overflow, no pending bit is set.
  - TCON write clearing bit 2 coinciding with an overflow that sets it: the set wins, so no interrupt is lost.
  - TCON write setting enable=0 coinciding with a tick: that tick still applies; counting stops from the next cycle.
  - TH write coinciding with an overflow: TL reloads the old TH; the new TH applies to the next overflow.
- Address match: exact 32-bit compare on addr[31:2] with addr[1:0] ignored. Any other address gives sel=0, rdata=0, and no state change.
- MemRead and MemWrite both high on the same address: the write happens and rdata shows the pre-write value.
- Reset asserted mid-count clears all state immediately. No tick occurs on the edge at which reset is released.

Decomposition:
- Shared package timer_pkg holds:
  - TH_OFF=0, TL_OFF=4, TCON_OFF=8.
  - TCON_EN=0, TCON_IE=1, TCON_PEND=2 bit indices.
  - The default BASE_ADDR.
- One sub-module, timer_prescaler, takes clk, reset, en and clr and outputs tick. It is parameterised by PRESCALE and PS_W.
- Register file, bus decode and IRQ logic stay in timer_irq_unit.

Test Plan:
- Reset, then TH=32'hFFFFFFF0, TL=32'hFFFFFFFE, TCON=3 with PRESCALE=1:
  - TL goes to FFFFFFFF after 1 cycle, then reloads FFFFFFF0.
  - TCON reads 7 and IRQ=1 one cycle after the reload.
- Same setup but TCON=1 (interrupt disabled): TL reloads and IRQ stays 0 for 40 cycles; TCON reads 1.
- Pending set, write TCON=3: IRQ=0 next cycle, TCON reads 3. Writing TCON=7 instead leaves IRQ=1.
- Clear-versus-overflow race: time a TCON=3 write onto the overflow edge; TCON reads 7 and IRQ=1 afterwards.
- PRESCALE=4, TL=0, TCON=1: TL reads 0,0,0,1 over cycles 1..4 and reaches 5 after 20 cycles. A TL write of 9 mid-window restarts the count: TL=10 exactly 4 cycles later.
- Assert reset while TL=123 and IRQ=1: all registers read 0 and IRQ=0 immediately. A read of address 32'h4000000C returns 0 with sel=0.
